// File: rtl/chnl_fifo_loopback.sv
// Channel loopback: each RX transaction is buffered in a first-word-fall-through
// FIFO and returned as one TX transaction of the same length. A per-transaction
// word transform (pass, invert, add constant, byte reverse) is applied on the way out.
module chnl_fifo_loopback #(
  parameter int          C_PCI_DATA_WIDTH = 32,
  parameter int          C_FIFO_DEPTH     = 64,
  parameter logic [31:0] C_ADD_CONST      = 32'd1
) (
  input  logic                        down_clk,
  input  logic                        RST,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN,
  output logic                        CHNL_TX_CLK,
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN
);

  localparam int          W        = C_PCI_DATA_WIDTH / 32;
  localparam int          WLOG     = $clog2(W);
  localparam int          AW       = $clog2(C_FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(C_FIFO_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_ACK, R_RECV} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_SEND} tx_state_t;

  rx_state_t rx_state;
  tx_state_t tx_state;

  logic [31:0] r_len;
  logic [31:0] r_beats;
  logic [31:0] rcv_cnt;
  logic [31:0] t_beats;
  logic [1:0]  mode;
  logic        rx_ack;
  logic        tx_req;

  logic [C_PCI_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [AW:0]                 count;
  logic                        full;
  logic                        empty;
  logic                        push;
  logic                        pop;

  logic [32:0]                 beats_wide;
  logic [C_PCI_DATA_WIDTH-1:0] head_x;
  logic                        unused_ok;

  // Word transform selected by the latched mode
  function automatic logic [31:0] xform(input logic [31:0] w, input logic [1:0] m);
    case (m)
      2'd0:    xform = w;
      2'd1:    xform = ~w;
      2'd2:    xform = w + C_ADD_CONST;
      default: xform = {w[7:0], w[15:8], w[23:16], w[31:24]};
    endcase
  endfunction

  // 33-bit sum keeps LEN = 0xFFFFFFFF from wrapping before the divide by W
  assign beats_wide = ({1'b0, CHNL_RX_LEN} + 33'(W - 1)) >> WLOG;

  assign full               = (count == FULL_CNT);
  assign empty              = (count == '0);
  assign CHNL_RX_DATA_REN   = (rx_state == R_RECV) && !full;
  assign push               = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
  assign CHNL_TX_DATA_VALID = (tx_state == T_SEND) && !empty;
  assign pop                = CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN;

  assign CHNL_RX_CLK  = down_clk;
  assign CHNL_TX_CLK  = down_clk;
  assign CHNL_RX_ACK  = rx_ack;
  assign CHNL_TX      = tx_req;
  assign CHNL_TX_LAST = 1'b1;
  assign CHNL_TX_LEN  = r_len;
  assign CHNL_TX_OFF  = '0;
  assign CHNL_TX_DATA = head_x;

  assign unused_ok = ^{CHNL_RX_LAST, CHNL_RX_OFF[30:2], beats_wide[32]};

  // RX FSM: accept a request only when TX is idle, ack once, then count pushes
  always_ff @(posedge down_clk or posedge RST) begin
    if (RST) begin
      rx_state <= R_IDLE;
      r_len    <= '0;
      r_beats  <= '0;
      rcv_cnt  <= '0;
      mode     <= '0;
      rx_ack   <= 1'b0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          rx_ack <= 1'b0;
          if (CHNL_RX && (tx_state == T_IDLE)) begin
            r_len    <= CHNL_RX_LEN;
            r_beats  <= beats_wide[31:0];
            mode     <= CHNL_RX_OFF[1:0];
            rcv_cnt  <= '0;
            rx_ack   <= 1'b1;
            rx_state <= R_ACK;
          end
        end
        R_ACK: begin
          rx_ack   <= 1'b0;
          rx_state <= (r_len == '0) ? R_IDLE : R_RECV;
        end
        R_RECV: begin
          if (push) begin
            rcv_cnt <= rcv_cnt + 32'd1;
            if (rcv_cnt == r_beats - 32'd1) rx_state <= R_IDLE;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // TX FSM: request as soon as RX is accepted, stream until the last beat pops
  always_ff @(posedge down_clk or posedge RST) begin
    if (RST) begin
      tx_state <= T_IDLE;
      t_beats  <= '0;
      tx_req   <= 1'b0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if ((rx_state == R_ACK) && (r_len != '0)) begin
            t_beats  <= '0;
            tx_req   <= 1'b1;
            tx_state <= T_REQ;
          end
        end
        T_REQ: begin
          if (CHNL_TX_ACK) tx_state <= T_SEND;
        end
        T_SEND: begin
          if (pop) begin
            t_beats <= t_beats + 32'd1;
            if (t_beats == r_beats - 32'd1) begin
              tx_req   <= 1'b0;
              tx_state <= T_IDLE;
            end
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge down_clk or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, data only
  always_ff @(posedge down_clk) begin
    if (push) mem[wr_ptr] <= CHNL_RX_DATA;
  end

  // Fall-through head with per-word transform, zero when nothing is offered
  always_comb begin
    head_x = '0;
    if (CHNL_TX_DATA_VALID) begin
      for (int i = 0; i < W; i++) begin
        head_x[i*32 +: 32] = xform(mem[rd_ptr][i*32 +: 32], mode);
      end
    end
  end

endmodule

// File: tb/tb_chnl_fifo_loopback.sv
// Bench for chnl_fifo_loopback: a 32-bit/depth-4 and a 64-bit/depth-8 instance
// share one stimulus driver; sel picks which instance a transaction targets.
module tb_chnl_fifo_loopback;

  localparam logic [31:0] ADD = 32'd1;

  logic        down_clk = 1'b0;
  logic        RST;
  logic        sel;
  logic        rx_req, rx_valid, rx_last, tx_ack, tx_ren;
  logic [31:0] rx_len;
  logic [30:0] rx_off;
  logic [63:0] rx_data;

  logic        a_rx_clk, a_rx_ack, a_rx_ren, a_tx_clk, a_tx, a_tx_last, a_tx_valid;
  logic [31:0] a_tx_len, a_tx_data;
  logic [30:0] a_tx_off;
  logic        b_rx_clk, b_rx_ack, b_rx_ren, b_tx_clk, b_tx, b_tx_last, b_tx_valid;
  logic [31:0] b_tx_len;
  logic [63:0] b_tx_data;
  logic [30:0] b_tx_off;

  logic        o_rx_clk, o_ack, o_rx_ren, o_tx_clk, o_tx, o_tx_last, o_tx_valid;
  logic [31:0] o_tx_len;
  logic [30:0] o_tx_off;
  logic [63:0] o_tx_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] dir_words[$];

  always #5 down_clk = ~down_clk;

  chnl_fifo_loopback #(.C_PCI_DATA_WIDTH(32), .C_FIFO_DEPTH(4), .C_ADD_CONST(ADD)) dut32 (
    .down_clk(down_clk), .RST(RST), .CHNL_RX_CLK(a_rx_clk),
    .CHNL_RX(rx_req & ~sel), .CHNL_RX_ACK(a_rx_ack), .CHNL_RX_LAST(rx_last),
    .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(rx_off), .CHNL_RX_DATA(rx_data[31:0]),
    .CHNL_RX_DATA_VALID(rx_valid & ~sel), .CHNL_RX_DATA_REN(a_rx_ren),
    .CHNL_TX_CLK(a_tx_clk), .CHNL_TX(a_tx), .CHNL_TX_ACK(tx_ack & ~sel),
    .CHNL_TX_LAST(a_tx_last), .CHNL_TX_LEN(a_tx_len), .CHNL_TX_OFF(a_tx_off),
    .CHNL_TX_DATA(a_tx_data), .CHNL_TX_DATA_VALID(a_tx_valid),
    .CHNL_TX_DATA_REN(tx_ren & ~sel)
  );

  chnl_fifo_loopback #(.C_PCI_DATA_WIDTH(64), .C_FIFO_DEPTH(8), .C_ADD_CONST(ADD)) dut64 (
    .down_clk(down_clk), .RST(RST), .CHNL_RX_CLK(b_rx_clk),
    .CHNL_RX(rx_req & sel), .CHNL_RX_ACK(b_rx_ack), .CHNL_RX_LAST(rx_last),
    .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(rx_off), .CHNL_RX_DATA(rx_data),
    .CHNL_RX_DATA_VALID(rx_valid & sel), .CHNL_RX_DATA_REN(b_rx_ren),
    .CHNL_TX_CLK(b_tx_clk), .CHNL_TX(b_tx), .CHNL_TX_ACK(tx_ack & sel),
    .CHNL_TX_LAST(b_tx_last), .CHNL_TX_LEN(b_tx_len), .CHNL_TX_OFF(b_tx_off),
    .CHNL_TX_DATA(b_tx_data), .CHNL_TX_DATA_VALID(b_tx_valid),
    .CHNL_TX_DATA_REN(tx_ren & sel)
  );

  assign o_rx_clk   = sel ? b_rx_clk   : a_rx_clk;
  assign o_ack      = sel ? b_rx_ack   : a_rx_ack;
  assign o_rx_ren   = sel ? b_rx_ren   : a_rx_ren;
  assign o_tx_clk   = sel ? b_tx_clk   : a_tx_clk;
  assign o_tx       = sel ? b_tx       : a_tx;
  assign o_tx_last  = sel ? b_tx_last  : a_tx_last;
  assign o_tx_valid = sel ? b_tx_valid : a_tx_valid;
  assign o_tx_len   = sel ? b_tx_len   : a_tx_len;
  assign o_tx_off   = sel ? b_tx_off   : a_tx_off;
  assign o_tx_data  = sel ? b_tx_data  : {32'h0, a_tx_data};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference transform, written from the mode table
  function automatic logic [31:0] ref_word(input logic [31:0] w, input int m);
    logic [31:0] r;
    case (m)
      0: r = w;
      1: r = 32'hFFFF_FFFF - w;
      2: r = w + ADD;
      default: for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
    endcase
    return r;
  endfunction

  task automatic chk_reset_state(input string t);
    chk({t, "_ack"},    o_ack,      0);
    chk({t, "_rxren"},  o_rx_ren,   0);
    chk({t, "_tx"},     o_tx,       0);
    chk({t, "_txvld"},  o_tx_valid, 0);
    chk({t, "_txlen"},  o_tx_len,   0);
    chk({t, "_txdata"}, o_tx_data,  0);
    chk({t, "_txlast"}, o_tx_last,  1);
    chk({t, "_txoff"},  o_tx_off,   0);
    chk({t, "_rxclk"},  o_rx_clk,   down_clk);
    chk({t, "_txclk"},  o_tx_clk,   down_clk);
  endtask

  // One transaction: s=instance, pv/pr = percent chance of VALID / TX REN per cycle,
  // hold = cycles TX REN is forced low, exp_push = beats expected accepted by then,
  // abort_at = beats pushed before RST is asserted (-1 = never)
  task automatic run_txn(input int s, input int len, input int mode, input int pv,
                         input int pr, input int hold, input int exp_push, input int abort_at);
    int w, nb, rx_i, tx_i, acks, cyc, ack_cyc, k;
    bit got_ack, tx_acked, tx_seen, done, aborted, last_pop;
    logic [63:0] rxb[$];
    logic [63:0] exb[$];
    logic [63:0] rb, eb;
    logic [31:0] wd;
    w = (s == 1) ? 2 : 1;
    nb = (len + w - 1) / w;
    for (int b = 0; b < nb; b++) begin
      rb = '0;
      eb = '0;
      for (int j = 0; j < w; j++) begin
        k  = b * w + j;
        wd = (k < dir_words.size()) ? dir_words[k] : $urandom;
        rb[j*32 +: 32] = wd;
        eb[j*32 +: 32] = ref_word(wd, mode);
      end
      rxb.push_back(rb);
      exb.push_back(eb);
    end
    sel = s[0];
    rx_len = len;
    rx_off = 31'($urandom);
    rx_off[1:0] = 2'(mode);
    rx_i = 0; tx_i = 0; acks = 0; cyc = 0; ack_cyc = 0;
    got_ack = 0; tx_acked = 0; tx_seen = 0; done = 0; aborted = 0; last_pop = 0;
    while (!done && !aborted && cyc < 3000) begin
      @(negedge down_clk);
      cyc++;
      if (last_pop) begin
        chk("tx_drop", o_tx, 0);
        chk("fifo_empty", o_tx_valid, 0);
        last_pop = 0;
        done = 1;
      end
      if (o_ack) begin
        acks++;
        got_ack = 1;
        ack_cyc = cyc;
      end
      if (o_tx) tx_seen = 1;
      if (abort_at >= 0 && got_ack && rx_i == abort_at) begin
        rx_req = 0; rx_valid = 0; tx_ack = 0; tx_ren = 0;
        RST = 1;
        #1;
        chk_reset_state("abort");
        @(negedge down_clk);
        RST = 0;
        aborted = 1;
      end else begin
        rx_req   = !got_ack;
        rx_valid = got_ack && (rx_i < nb) && ($urandom_range(99, 0) < pv);
        rx_data  = (rx_valid) ? rxb[rx_i] : {$urandom, $urandom};
        tx_ack   = o_tx && !tx_acked && ($urandom_range(1, 0) == 1);
        if (tx_ack) begin
          tx_acked = 1;
          chk("tx_len", o_tx_len, len);
        end
        tx_ren = (cyc > hold) && ($urandom_range(99, 0) < pr);
        #1;
        if (hold > 0 && cyc == hold && exp_push >= 0) begin
          chk("bp_pushed", rx_i, exp_push);
          chk("bp_rxren", o_rx_ren, 0);
        end
        if (rx_valid && o_rx_ren) rx_i++;
        if (o_tx_valid && tx_ren) begin
          if (tx_i < nb) begin
            chk($sformatf("tx_data[%0d]", tx_i), o_tx_data, exb[tx_i]);
            tx_i++;
            if (tx_i == nb) last_pop = 1;
          end else begin
            chk("extra_pop", tx_i, nb - 1);
          end
        end
        if (len == 0 && got_ack && cyc >= ack_cyc + 3) done = 1;
      end
    end
    rx_req = 0; rx_valid = 0; tx_ack = 0; tx_ren = 0;
    if (!aborted) begin
      chk("done", done, 1);
      chk("acks", acks, 1);
      chk("tx_seen", tx_seen, (len != 0));
      chk("rx_beats", rx_i, nb);
      chk("tx_beats", tx_i, nb);
    end
  endtask

  initial begin
    RST = 1; sel = 0; rx_req = 0; rx_valid = 0; rx_last = 0; tx_ack = 0; tx_ren = 0;
    rx_len = '0; rx_off = '0; rx_data = '0;
    repeat (3) @(negedge down_clk);
    chk_reset_state("rst32");
    sel = 1;
    #1;
    chk_reset_state("rst64");
    @(negedge down_clk);
    RST = 0;
    @(negedge down_clk);

    // Plain loopback, data 1..8, never stalled
    dir_words = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    run_txn(0, 8, 0, 100, 100, 0, -1, -1);
    // Transform modes
    dir_words = {32'h0000_0000, 32'hFFFF_0000};
    run_txn(0, 2, 1, 100, 100, 0, -1, -1);
    dir_words = {32'hFFFF_FFFF};
    run_txn(0, 1, 2, 100, 100, 0, -1, -1);
    dir_words = {32'h1122_3344};
    run_txn(0, 1, 3, 100, 100, 0, -1, -1);
    dir_words = {32'h1122_3344, 32'hFFFF_FFFF};
    run_txn(1, 2, 3, 100, 100, 0, -1, -1);
    dir_words = {};
    // Backpressure against a depth-4 FIFO
    run_txn(0, 10, 0, 100, 100, 20, 4, -1);
    // 64-bit path with a padded final beat
    run_txn(1, 5, 0, 100, 100, 0, -1, -1);
    // Zero-length requests
    run_txn(0, 0, 0, 100, 100, 0, -1, -1);
    run_txn(1, 0, 2, 100, 100, 0, -1, -1);
    // Reset mid-transfer, then a clean transaction
    run_txn(0, 8, 1, 100, 100, 0, -1, 3);
    run_txn(0, 4, 0, 100, 100, 0, -1, -1);
    run_txn(1, 8, 2, 100, 60, 0, -1, 2);
    run_txn(1, 4, 3, 100, 100, 0, -1, -1);
    // Randomized traffic on both instances
    for (int n = 0; n < 20; n++) begin
      run_txn($urandom_range(1, 0), $urandom_range(24, 1), $urandom_range(3, 0),
              $urandom_range(100, 30), $urandom_range(100, 30), 0, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
